// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared state encoding and lane output transforms for the SFU accumulate bank
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LAST  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Lane transforms work at a fixed wide width so any ACC_BW/OUT_BW pair fits.
  localparam int CALC_BW = 64;

  function automatic logic signed [CALC_BW-1:0] relu(input logic signed [CALC_BW-1:0] v);
    return v[CALC_BW-1] ? '0 : v;
  endfunction

  function automatic logic signed [CALC_BW-1:0] sat(input logic signed [CALC_BW-1:0] v,
                                                     input int out_bw);
    logic signed [CALC_BW-1:0] hi;
    logic signed [CALC_BW-1:0] lo;
    hi = (64'sd1 <<< (out_bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfu_acc_buf.sv
// rtl/sfu_acc_buf.sv - DEPTH-entry accumulation buffer, combinational read, one synchronous write
module sfu_acc_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 192
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfu_accum_bank.sv
// rtl/sfu_accum_bank.sv - multi-pass psum accumulator with ReLU/saturation and a valid/ready result stream
module sfu_accum_bank
  import sfu_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 24,
  parameter int OUT_BW  = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int PW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW:0]            cfg_len,
  input  logic [PW-1:0]          cfg_passes,
  input  logic                   cfg_relu,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] in_psum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*OUT_BW-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [PW-1:0]        pass_q, pass_d;
  logic [AW:0]          len_q, len_d;
  logic [PW-1:0]        passes_q, passes_d;
  logic                 relu_q, relu_d;
  logic                 out_valid_q, out_valid_d;
  logic [COL*OUT_BW-1:0] out_data_q, out_data_d;
  logic                 done_q, done_d;

  logic [PW-1:0]        passes_eff;
  logic                 first_pass;
  logic                 last_vec;
  logic                 out_free;
  logic                 buf_we;
  logic [COL*ACC_BW-1:0] buf_rdata;
  logic [COL*ACC_BW-1:0] buf_wdata;
  logic [COL*OUT_BW-1:0] result;

  assign passes_eff = (cfg_passes == '0) ? PW'(1) : cfg_passes;
  assign first_pass = (pass_q == '0);
  assign last_vec   = ({1'b0, addr_q} == (len_q - 1'b1));
  assign out_free   = !out_valid_q || out_ready;

  sfu_acc_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (COL*ACC_BW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (addr_q),
    .wdata (buf_wdata),
    .raddr (addr_q),
    .rdata (buf_rdata)
  );

  // On the first pass the buffer content is stale, so the input alone is the running sum.
  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic signed [PSUM_BW-1:0] psum;
    logic signed [ACC_BW-1:0]  ext;
    logic signed [ACC_BW-1:0]  prev;
    logic signed [ACC_BW-1:0]  sum;

    assign psum = in_psum[i*PSUM_BW +: PSUM_BW];
    assign ext  = ACC_BW'(psum);
    assign prev = buf_rdata[i*ACC_BW +: ACC_BW];
    assign sum  = first_pass ? ext : prev + ext;

    assign buf_wdata[i*ACC_BW +: ACC_BW] = sum;
    assign result[i*OUT_BW +: OUT_BW] =
      OUT_BW'(sat(relu_q ? relu(CALC_BW'(sum)) : CALC_BW'(sum), OUT_BW));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    len_d       = len_q;
    passes_d    = passes_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q still high means the job is finishing this cycle; busy covers it.
        if (start && !done_q) begin
          len_d    = cfg_len;
          passes_d = passes_eff;
          relu_d   = cfg_relu;
          addr_d   = '0;
          pass_d   = '0;
          if (cfg_len == '0)           state_d = FLUSH;
          else if (passes_eff == PW'(1)) state_d = LAST;
          else                         state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          if (last_vec) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if ((pass_q + 1'b1) == (passes_q - 1'b1)) state_d = LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      LAST: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          if (last_vec) begin
            addr_d  = '0;
            state_d = FLUSH;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == LAST && in_valid && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pass_q      <= '0;
      len_q       <= '0;
      passes_q    <= PW'(1);
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      len_q       <= len_d;
      passes_q    <= passes_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_sfu_accum_bank.sv
// tb/tb_sfu_accum_bank.sv - scoreboard bench for sfu_accum_bank with hand-computed directed vectors
module tb_sfu_accum_bank;

  localparam int COL = 8, PSUM_BW = 16, ACC_BW = 24, OUT_BW = 16, DEPTH = 16, AW = 4, PW = 4;
  localparam int IW = COL*PSUM_BW;
  localparam int OW = COL*OUT_BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic [PW-1:0] cfg_passes = '0;
  logic          cfg_relu = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_psum = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;
  logic [OW-1:0] exp_q[$];

  sfu_accum_bank #(
    .COL(COL), .PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW), .OUT_BW(OUT_BW),
    .DEPTH(DEPTH), .AW(AW), .PW(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_passes(cfg_passes), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .in_ready(in_ready), .in_psum(in_psum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] mk_in(input int l0, input int l3, input int f);
    logic [IW-1:0] v;
    for (int i = 0; i < COL; i++)
      v[i*PSUM_BW +: PSUM_BW] = (i == 0) ? l0[PSUM_BW-1:0] : (i == 3) ? l3[PSUM_BW-1:0] : f[PSUM_BW-1:0];
    return v;
  endfunction

  function automatic logic [OW-1:0] mk_out(input int l0, input int l3, input int f);
    logic [OW-1:0] v;
    for (int i = 0; i < COL; i++)
      v[i*OUT_BW +: OUT_BW] = (i == 0) ? l0[OUT_BW-1:0] : (i == 3) ? l3[OUT_BW-1:0] : f[OUT_BW-1:0];
    return v;
  endfunction

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("unexpected_out", out_data, '0 - 1);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic start_job(input int len, input int passes, input bit relu);
    cfg_len = (AW+1)'(len); cfg_passes = PW'(passes); cfg_relu = relu;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [IW-1:0] v, output int waits);
    waits = 0;
    in_psum = v; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 200) begin waits++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", OW'(0), OW'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int exp_cyc);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 100);
    chk("done_latency", OW'(cyc), OW'(exp_cyc));
    chk("busy_at_done", OW'(busy), OW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    int oc;
    logic [OW-1:0] held;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", OW'(in_ready), OW'(0));
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_done", OW'(done), OW'(0));
    @(posedge clk); #1;

    // single pass, full-scale values pass through unchanged
    exp_q.push_back(mk_out(5, 10, -1));
    exp_q.push_back(mk_out(-3, 20, -1));
    exp_q.push_back(mk_out(32767, 30, -1));
    exp_q.push_back(mk_out(-32768, 40, -1));
    start_job(4, 1, 0);
    chk("busy_after_start", OW'(busy), OW'(1));
    send_vec(mk_in(5, 10, -1), w);
    chk("latency1_valid", OW'(out_valid), OW'(1));
    send_vec(mk_in(-3, 20, -1), w);
    send_vec(mk_in(32767, 30, -1), w);
    send_vec(mk_in(-32768, 40, -1), w);
    in_valid = 1'b0;
    wait_done(2);
    @(negedge clk);
    chk("busy_after_done", OW'(busy), OW'(0));

    // three passes, lane0 saturates both ways
    exp_q.push_back(mk_out(32767, 3000, 21));
    exp_q.push_back(mk_out(-32768, -3000, 21));
    @(posedge clk); #1;
    start_job(2, 3, 0);
    for (int p = 0; p < 3; p++) begin
      send_vec(mk_in(20000, 1000, 7), w);
      send_vec(mk_in(-20000, -1000, 7), w);
    end
    in_valid = 1'b0;
    wait_done(2);

    // ReLU on and off over the same two-pass stimulus
    for (int r = 1; r >= 0; r--) begin
      exp_q.push_back(r ? mk_out(30, 0, 0) : mk_out(30, -5, -8));
      @(posedge clk); #1;
      start_job(1, 2, r[0]);
      send_vec(mk_in(10, -7, -4), w);
      send_vec(mk_in(20, 2, -4), w);
      in_valid = 1'b0;
      wait_done(2);
    end

    // backpressure: result held, input stalled, then full rate
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_out(100 + k, -k, 3));
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_job(4, 1, 0);
    send_vec(mk_in(100, 0, 3), w);
    in_psum = mk_in(101, -1, 3);
    held = mk_out(100, 0, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", OW'(in_ready), OW'(0));
      chk("bp_out_stable", out_data, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      send_vec(mk_in(100 + k, -k, 3), w);
      chk("full_rate_wait", OW'(w), OW'(0));
    end
    in_valid = 1'b0;
    wait_done(2);

    // cfg_len=0: done two cycles after start, no output
    @(posedge clk); #1;
    oc = out_cnt;
    start_job(0, 2, 0);
    wait_done(2);
    chk("len0_no_out", OW'(out_cnt), OW'(oc));

    // passes=0 acts as one pass; a start while busy is ignored
    exp_q.push_back(mk_out(-9, 9, 1));
    exp_q.push_back(mk_out(1234, -1234, 1));
    @(posedge clk); #1;
    start_job(2, 0, 0);
    start_job(0, 3, 1);
    send_vec(mk_in(-9, 9, 1), w);
    send_vec(mk_in(1234, -1234, 1), w);
    in_valid = 1'b0;
    wait_done(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("start_in_done_ignored", OW'({busy, done}), OW'(0));
    end

    // full depth, two passes
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(mk_out(101 * k, -2 * k, 0));
    @(posedge clk); #1;
    start_job(DEPTH, 2, 0);
    for (int k = 0; k < DEPTH; k++) send_vec(mk_in(k, -k, 0), w);
    for (int k = 0; k < DEPTH; k++) send_vec(mk_in(100 * k, -k, 0), w);
    in_valid = 1'b0;
    wait_done(2);

    // reset during pass 1 of ACCUM, then a single-pass job sees raw inputs
    @(posedge clk); #1;
    start_job(4, 3, 0);
    for (int k = 0; k < 5; k++) send_vec(mk_in(1000, 1000, 1000), w);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", OW'(in_ready), OW'(0));
    chk("midrst_out_valid", OW'(out_valid), OW'(0));
    chk("midrst_busy_done", OW'({busy, done}), OW'(0));
    chk("midrst_out_data", out_data, '0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_out(k + 1, -(k + 1), 2));
    @(posedge clk); #1;
    start_job(4, 1, 0);
    for (int k = 0; k < 4; k++) send_vec(mk_in(k + 1, -(k + 1), 2), w);
    in_valid = 1'b0;
    wait_done(2);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", OW'(exp_q.size()), OW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
